// File: rtl/gf_fit_pkg.sv
// Shared constants and types for the GigaFitter MAC stage.
// Default widths, FSM encoding and term-flag layout.
package gf_fit_pkg;

    localparam int GF_IN_W      = 18;
    localparam int GF_ACC_W     = 48;
    localparam int GF_OUT_W     = 32;
    localparam int GF_SHIFT     = 12;
    localparam int GF_MAX_TERMS = 16;
    localparam int CNT_W        = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        EMIT  = 2'd2
    } gf_state_t;

    localparam int FLAG_FIRST = 0;
    localparam int FLAG_LAST  = 1;
    localparam int FLAG_W     = 2;

    // Pack the per-term flags; both are gated by the term valid.
    function automatic logic [FLAG_W-1:0] mk_flags(
        input logic dv,
        input logic first,
        input logic last
    );
        logic [FLAG_W-1:0] f;
        f             = '0;
        f[FLAG_FIRST] = dv & first;
        f[FLAG_LAST]  = dv & last;
        return f;
    endfunction

endpackage

// File: rtl/gf_mult_stage.sv
// Registered signed multiplier with term-flag pass-through.
// One product per cycle; maps onto a DSP multiplier block.
module gf_mult_stage
    import gf_fit_pkg::*;
#(
    parameter int IN_W = GF_IN_W
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_dv,
    input  logic [FLAG_W-1:0]   i_flags,
    input  logic [IN_W-1:0]     i_a,
    input  logic [IN_W-1:0]     i_b,
    output logic                o_dv,
    output logic [FLAG_W-1:0]   o_flags,
    output logic [2*IN_W-1:0]   o_prod
);

    localparam int PROD_W = 2 * IN_W;

    logic signed [PROD_W-1:0] w_a;
    logic signed [PROD_W-1:0] w_b;
    logic                     r_dv;
    logic [FLAG_W-1:0]        r_flags;
    logic [PROD_W-1:0]        r_prod;

    assign w_a = {{IN_W{i_a[IN_W-1]}}, i_a};
    assign w_b = {{IN_W{i_b[IN_W-1]}}, i_b};

    // Product register; flags and valid ride along with it.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_dv    <= 1'b0;
            r_flags <= '0;
            r_prod  <= '0;
        end else begin
            r_dv    <= i_dv;
            r_flags <= i_flags;
            r_prod  <= w_a * w_b;
        end
    end

    assign o_dv    = r_dv;
    assign o_flags = r_flags;
    assign o_prod  = r_prod;

endmodule

// File: rtl/gf_mac_accum.sv
// Pipelined signed MAC: per-track scalar product of COEF x HIT.
// Optional GF_ACC_SAT_EN saturates the output and flags clipping.
module gf_mac_accum
    import gf_fit_pkg::*;
#(
    parameter int IN_W      = GF_IN_W,
    parameter int ACC_W     = GF_ACC_W,
    parameter int OUT_W     = GF_OUT_W,
    parameter int SHIFT     = GF_SHIFT,
    parameter int MAX_TERMS = GF_MAX_TERMS
) (
    input  logic             CLOCK,
    input  logic             RESET_N,
    input  logic             DV_IN,
    input  logic             MODECP,
    input  logic             MODE0,
    input  logic [IN_W-1:0]  COEF,
    input  logic [IN_W-1:0]  HIT,
    output logic [OUT_W-1:0] RESULT,
    output logic             RES_VALID,
    output logic             ERR,
    output logic [4:0]       NTERMS,
    output logic             BUSY
);

    localparam int PROD_W = 2 * IN_W;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);

    logic                    r_dv;
    logic [FLAG_W-1:0]       r_flags;
    logic [IN_W-1:0]         r_coef;
    logic [IN_W-1:0]         r_hit;

    logic                    w_p_dv;
    logic [FLAG_W-1:0]       w_p_flags;
    logic [PROD_W-1:0]       w_prod;
    logic signed [ACC_W-1:0] w_prod_ext;
    logic                    w_first;
    logic                    w_last;

    gf_state_t               r_state;
    gf_state_t               w_state_nxt;
    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_acc_nxt;
    logic [CNT_W-1:0]        r_cnt;
    logic [CNT_W-1:0]        w_cnt_nxt;
    logic                    r_err_q;
    logic                    w_err_ev;
    logic                    r_abort_q;
    logic                    w_abort_ev;
    logic [CNT_W-1:0]        r_abort_cnt;
    logic [CNT_W-1:0]        w_abort_cnt;

    logic signed [ACC_W-1:0] w_shift;
    logic [OUT_W-1:0]        w_conv;
    logic                    w_emit;

    logic [OUT_W-1:0]        r_result;
    logic                    r_res_valid;
    logic                    r_err;
    logic [CNT_W-1:0]        r_nterms;

    // Input register: term and its flags, flags masked by DV_IN.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_dv    <= 1'b0;
            r_flags <= '0;
            r_coef  <= '0;
            r_hit   <= '0;
        end else begin
            r_dv    <= DV_IN;
            r_flags <= mk_flags(DV_IN, MODECP, MODE0);
            r_coef  <= COEF;
            r_hit   <= HIT;
        end
    end

    gf_mult_stage #(
        .IN_W (IN_W)
    ) u_mult (
        .i_clk   (CLOCK),
        .i_rst_n (RESET_N),
        .i_dv    (r_dv),
        .i_flags (r_flags),
        .i_a     (r_coef),
        .i_b     (r_hit),
        .o_dv    (w_p_dv),
        .o_flags (w_p_flags),
        .o_prod  (w_prod)
    );

    assign w_prod_ext = {{(ACC_W-PROD_W){w_prod[PROD_W-1]}}, w_prod};
    assign w_first    = w_p_dv & w_p_flags[FLAG_FIRST];
    assign w_last     = w_p_dv & w_p_flags[FLAG_LAST];
    assign w_emit     = (r_state == EMIT);

    // Track FSM and accumulator next-state at the accumulate stage.
    always_comb begin
        w_state_nxt = r_state;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_err_ev    = 1'b0;
        w_abort_ev  = 1'b0;
        w_abort_cnt = r_cnt;
        if (r_state == EMIT) begin
            w_state_nxt = IDLE;
        end
        if (w_p_dv) begin
            unique case (r_state)
                ACCUM: begin
                    if (w_first) begin
                        w_err_ev    = 1'b1;
                        w_abort_ev  = 1'b1;
                        w_acc_nxt   = w_prod_ext;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = w_last ? EMIT : ACCUM;
                    end else if (r_cnt == MAX_CNT) begin
                        w_err_ev    = 1'b1;
                        w_abort_ev  = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_acc_nxt   = r_acc + w_prod_ext;
                        w_cnt_nxt   = r_cnt + CNT_W'(1);
                        w_state_nxt = w_last ? EMIT : ACCUM;
                    end
                end
                default: begin
                    if (w_first) begin
                        w_acc_nxt   = w_prod_ext;
                        w_cnt_nxt   = CNT_W'(1);
                        w_state_nxt = w_last ? EMIT : ACCUM;
                    end else begin
                        w_err_ev    = 1'b1;
                        w_state_nxt = IDLE;
                    end
                end
            endcase
        end
    end

    // Accumulate-stage registers: state, sum, count, error events.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_err_q     <= 1'b0;
            r_abort_q   <= 1'b0;
            r_abort_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_cnt       <= w_cnt_nxt;
            r_err_q     <= w_err_ev;
            r_abort_q   <= w_abort_ev;
            r_abort_cnt <= w_abort_cnt;
        end
    end

    assign w_shift = r_acc >>> SHIFT;

`ifdef GF_ACC_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

    logic w_clip;

    // Saturating conversion of the scaled sum to the output width.
    always_comb begin
        w_clip = 1'b0;
        w_conv = w_shift[OUT_W-1:0];
        if (w_shift > SAT_MAX) begin
            w_clip = 1'b1;
            w_conv = {1'b0, {(OUT_W-1){1'b1}}};
        end else if (w_shift < SAT_MIN) begin
            w_clip = 1'b1;
            w_conv = {1'b1, {(OUT_W-1){1'b0}}};
        end
    end
`else
    logic w_unused_hi;

    assign w_conv      = w_shift[OUT_W-1:0];
    assign w_unused_hi = ^w_shift[ACC_W-1:OUT_W];
`endif

    // Output stage: result on EMIT, abort count otherwise, error strobe.
    always_ff @(posedge CLOCK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_result    <= '0;
            r_res_valid <= 1'b0;
            r_err       <= 1'b0;
            r_nterms    <= '0;
        end else begin
            r_res_valid <= w_emit;
`ifdef GF_ACC_SAT_EN
            r_err       <= r_err_q | (w_clip & w_emit);
`else
            r_err       <= r_err_q;
`endif
            if (w_emit) begin
                r_result <= w_conv;
                r_nterms <= r_cnt;
            end else if (r_abort_q) begin
                r_nterms <= r_abort_cnt;
            end
        end
    end

    assign RESULT    = r_result;
    assign RES_VALID = r_res_valid;
    assign ERR       = r_err;
    assign NTERMS    = r_nterms;
    assign BUSY      = (r_state == ACCUM);

endmodule

// File: tb/tb_gf_mac_accum.sv
// Directed bench for gf_mac_accum with a timed output scoreboard.
// Honors GF_ACC_SAT_EN when the RTL is built with it.
module tb_gf_mac_accum;

    localparam int IN_W      = 18;
    localparam int ACC_W     = 48;
    localparam int OUT_W     = 32;
    localparam int SHIFT     = 0;
    localparam int MAX_TERMS = 16;

    logic             CLOCK   = 1'b0;
    logic             RESET_N = 1'b0;
    logic             DV_IN   = 1'b0;
    logic             MODECP  = 1'b0;
    logic             MODE0   = 1'b0;
    logic [IN_W-1:0]  COEF    = '0;
    logic [IN_W-1:0]  HIT     = '0;
    logic [OUT_W-1:0] RESULT;
    logic             RES_VALID;
    logic             ERR;
    logic [4:0]       NTERMS;
    logic             BUSY;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic        v;
        logic        err;
        logic [31:0] res;
        logic [4:0]  nt;
    } exp_t;

    exp_t q[$];

    logic               m_open = 1'b0;
    logic signed [47:0] m_acc  = '0;
    int                 m_cnt  = 0;
    logic [4:0]         m_nt   = '0;

    gf_mac_accum #(
        .IN_W      (IN_W),
        .ACC_W     (ACC_W),
        .OUT_W     (OUT_W),
        .SHIFT     (SHIFT),
        .MAX_TERMS (MAX_TERMS)
    ) dut (
        .CLOCK     (CLOCK),
        .RESET_N   (RESET_N),
        .DV_IN     (DV_IN),
        .MODECP    (MODECP),
        .MODE0     (MODE0),
        .COEF      (COEF),
        .HIT       (HIT),
        .RESULT    (RESULT),
        .RES_VALID (RES_VALID),
        .ERR       (ERR),
        .NTERMS    (NTERMS),
        .BUSY      (BUSY)
    );

    always #5 CLOCK = ~CLOCK;

    always @(posedge CLOCK) cyc <= cyc + 1;

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] conv(
        input logic signed [47:0] a,
        output logic clip
    );
        logic signed [47:0] s;
        s    = a >>> SHIFT;
        clip = 1'b0;
`ifdef GF_ACC_SAT_EN
        if (s > 48'sd2147483647) begin
            clip = 1'b1;
            return 32'h7fffffff;
        end
        if (s < -48'sd2147483648) begin
            clip = 1'b1;
            return 32'h80000000;
        end
`endif
        return s[31:0];
    endfunction

    // Drive one term for a cycle and record what it must produce.
    task automatic term(int c, int h, bit f, bit l);
        longint             pl;
        logic signed [47:0] p;
        logic               e;
        logic               em;
        logic               clip;
        logic [4:0]         nt;
        logic [31:0]        res;
        COEF   = IN_W'(c);
        HIT    = IN_W'(h);
        DV_IN  = 1'b1;
        MODECP = f;
        MODE0  = l;
        pl     = longint'(c) * longint'(h);
        p      = pl[47:0];
        e      = 1'b0;
        em     = 1'b0;
        clip   = 1'b0;
        nt     = m_nt;
        res    = '0;
        if (m_open) begin
            if (f) begin
                e      = 1'b1;
                nt     = 5'(m_cnt);
                m_open = 1'b0;
            end else if (m_cnt == MAX_TERMS) begin
                e      = 1'b1;
                nt     = 5'(m_cnt);
                m_open = 1'b0;
            end else begin
                m_acc = m_acc + p;
                m_cnt++;
                if (l) em = 1'b1;
            end
        end else if (!f) begin
            e = 1'b1;
        end
        if (f) begin
            m_acc = p;
            m_cnt = 1;
            if (l) em = 1'b1;
            else m_open = 1'b1;
        end
        if (em) begin
            m_open = 1'b0;
            res    = conv(m_acc, clip);
            nt     = 5'(m_cnt);
        end
        if (em || e) begin
            q.push_back('{cyc + 4, em, e | clip, res, nt});
            m_nt = nt;
        end
        @(negedge CLOCK);
        DV_IN  = 1'b0;
        MODECP = 1'b0;
        MODE0  = 1'b0;
    endtask

    // Idle cycles with the mode lines toggled to show they are ignored.
    task automatic bubble(int n);
        DV_IN  = 1'b0;
        MODECP = 1'b1;
        MODE0  = 1'b1;
        COEF   = IN_W'($urandom);
        HIT    = IN_W'($urandom);
        repeat (n) @(negedge CLOCK);
        MODECP = 1'b0;
        MODE0  = 1'b0;
    endtask

    // Output monitor: every strobe must match the next due entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLOCK);
            if (q.size() != 0 && q[0].cyc < cyc) begin
                checks++;
                assert (q[0].cyc >= cyc) else begin
                    errors++;
                    $error("FAIL missed_out due=%0d now=%0d",
                           q[0].cyc, cyc);
                end
                void'(q.pop_front());
            end
            if (q.size() != 0 && q[0].cyc == cyc) begin
                e = q.pop_front();
                chk("out_valid", 64'(RES_VALID), 64'(e.v));
                chk("out_err", 64'(ERR), 64'(e.err));
                chk("out_nterms", 64'(NTERMS), 64'(e.nt));
                if (e.v) chk("out_result", 64'(RESULT), 64'(e.res));
            end else begin
                checks++;
                assert (RES_VALID === 1'b0 && ERR === 1'b0) else begin
                    errors++;
                    $error("FAIL spurious_out cyc=%0d valid=%b err=%b expected 0/0",
                           cyc, RES_VALID, ERR);
                end
            end
        end
    end

    initial begin
        repeat (3) @(negedge CLOCK);
        chk("rst_result", 64'(RESULT), 64'd0);
        chk("rst_valid", 64'(RES_VALID), 64'd0);
        chk("rst_err", 64'(ERR), 64'd0);
        chk("rst_nterms", 64'(NTERMS), 64'd0);
        chk("rst_busy", 64'(BUSY), 64'd0);
        RESET_N = 1'b1;
        @(negedge CLOCK);

        term(2, 3, 1, 0);
        term(-4, 5, 0, 0);
        term(7, 1, 0, 1);
        chk("t1_busy_open", 64'(BUSY), 64'd1);
        repeat (5) @(negedge CLOCK);
        chk("t1_busy_done", 64'(BUSY), 64'd0);
        chk("t1_result", 64'(RESULT), 64'hffff_fff9);
        chk("t1_nterms", 64'(NTERMS), 64'd3);

        term(-131072, 131071, 1, 1);
        repeat (5) @(negedge CLOCK);
`ifdef GF_ACC_SAT_EN
        chk("t2_result", 64'(RESULT), 64'h8000_0000);
`else
        chk("t2_result", 64'(RESULT), 64'h0002_0000);
`endif

        term(5, 5, 0, 0);
        term(1, 1, 0, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t3_busy_idle", 64'(BUSY), 64'd0);
            @(negedge CLOCK);
        end

        term(3, 3, 1, 0);
        term(2, 2, 0, 0);
        term(1, 1, 1, 0);
        term(1, 1, 0, 1);
        repeat (5) @(negedge CLOCK);
        chk("t4_result", 64'(RESULT), 64'd2);
        chk("t4_nterms", 64'(NTERMS), 64'd2);

        term(4, 4, 1, 0);
        term(6, 1, 1, 1);
        repeat (5) @(negedge CLOCK);

        term(3, 4, 1, 0);
        term(5, 6, 0, 0);
        bubble(2);
        term(-1, 2, 0, 1);
        term(10, -10, 1, 0);
        term(100, 100, 0, 1);
        term(-9, 9, 1, 1);
        repeat (6) @(negedge CLOCK);
        chk("t6_last_result", 64'(RESULT), 64'hffff_ffaf);

        for (int i = 0; i < 16; i++) term(1000, 1000, i == 0, 0);
        term(1, 1, 0, 0);
        for (int i = 0; i < 16; i++) term(1000, 1000, i == 0, i == 15);
        repeat (5) @(negedge CLOCK);
        chk("t7_nterms", 64'(NTERMS), 64'd16);

        term(7, 7, 1, 1);
        repeat (5) @(negedge CLOCK);
        term(1, 2, 1, 0);
        term(3, 4, 0, 0);
        bubble(1);
        chk("t8_busy_mid", 64'(BUSY), 64'd1);
        #2;
        RESET_N = 1'b0;
        q.delete();
        m_open = 1'b0;
        m_acc  = '0;
        m_cnt  = 0;
        m_nt   = '0;
        #1;
        chk("t8_rst_result", 64'(RESULT), 64'd0);
        chk("t8_rst_nterms", 64'(NTERMS), 64'd0);
        chk("t8_rst_busy", 64'(BUSY), 64'd0);
        @(negedge CLOCK);
        @(negedge CLOCK);
        RESET_N = 1'b1;
        repeat (4) @(negedge CLOCK);
        term(2, 2, 1, 0);
        term(3, 3, 0, 1);
        repeat (6) @(negedge CLOCK);
        chk("t8_result", 64'(RESULT), 64'd13);

        checks++;
        assert (q.size() == 0) else begin
            errors++;
            $error("FAIL drain pending=%0d expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/gf_mac_accum.md
Name: gf_mac_accum

Overview:
- Pipelined signed multiply-accumulate stage directly downstream of dspcontrol in the GigaFitter mezzanine.
- Consumes dspcontrol's DVout/MODECP/MODE0 strobes together with coefficient and hit-coordinate words.
- Forms the per-track scalar product (sum of coefficient x hit) and emits one fit-parameter word per track, with a valid strobe for the output formatter.

Parameters:
- IN_W, 18, width of signed COEF and HIT operands
- ACC_W, 48, accumulator width (signed)
- OUT_W, 32, width of signed RESULT
- SHIFT, 12, arithmetic right shift applied to the accumulator before output (fixed-point scaling)
- MAX_TERMS, 16, maximum terms per track; more is an error

Ports:
- CLOCK  in  1  system clock, all logic on rising edge
- RESET_N  in  1  asynchronous, active-low reset
- DV_IN  in  1  term valid (dspcontrol DVout)
- MODECP  in  1  with DV_IN: first term of a track (load, do not add)
- MODE0  in  1  with DV_IN: last term of a track
- COEF  in  IN_W  signed coefficient
- HIT  in  IN_W  signed hit coordinate
- RESULT  out  OUT_W  scaled scalar product
- RES_VALID  out  1  one-cycle strobe, RESULT valid
- ERR  out  1  one-cycle strobe on protocol error
- NTERMS  out  5  term count of the last emitted/aborted track
- BUSY  out  1  high while a track is open

Behaviour:
- Reset (async, RESET_N=0): all pipeline registers, accumulator, RESULT, NTERMS = 0; RES_VALID, ERR, BUSY = 0; FSM = IDLE.
- Pipeline:
  - Edge k: a term with DV_IN=1 is registered together with its MODECP/MODE0 flags.
  - Edge k+1: product register updated (2*IN_W bits, sign-extended to ACC_W).
  - Edge k+2: accumulator updated.
  - Edge k+3: RESULT/RES_VALID updated for the last term of a track.
- Flags travel with the data through every stage.
- One term per cycle sustained; back-to-back tracks need no idle cycles.
- FSM, evaluated at the accumulator stage:
  - IDLE:
    - term with MODECP -> acc = product, count = 1, go to ACCUM (or EMIT if MODE0 is also set: single-term track).
    - term without MODECP -> dropped, ERR=1, stay in IDLE.
  - ACCUM:
    - term without MODECP -> acc += product, count++; MODE0 -> EMIT.
    - term with MODECP -> open track aborted: ERR=1, NTERMS = aborted count, no RES_VALID; new track loaded as in IDLE.
    - count reaching MAX_TERMS without MODE0: on the next term ERR=1, track discarded, back to IDLE, that term dropped.
  - EMIT (one cycle, accepts a new term like IDLE):
    - RESULT = acc >>> SHIFT, truncated to OUT_W; RES_VALID=1; NTERMS = count.
- DV_IN=0 cycles are bubbles: acc and FSM hold, and MODECP/MODE0 are ignored.
- BUSY = 1 from the load cycle until the EMIT cycle or an abort.
- ERR and RES_VALID may assert in the same cycle (abort followed immediately by a single-term track).
- Accumulator arithmetic wraps modulo 2^ACC_W.
- Reset asserted mid-track discards everything; no RES_VALID after release.

Optional Feature:
- GF_ACC_SAT_EN defined: output conversion saturates to [-2^(OUT_W-1), 2^(OUT_W-1)-1], and an extra sticky-free bit is OR-ed into ERR on the EMIT cycle when clipping occurs.
- Undefined: plain two's-complement truncation, no clip detection logic.

Decomposition:
- Package gf_fit_pkg holds:
  - IN_W/ACC_W/OUT_W defaults;
  - FSM state encoding localparams IDLE=2'd0, ACCUM=2'd1, EMIT=2'd2;
  - term-flag struct constants (FLAG_FIRST, FLAG_LAST bit positions).
- One sub-module, gf_mult_stage: registered signed multiplier with flag pass-through (maps to the DSP48 multiplier); the accumulator and FSM stay in the top.

Test Plan:
- Reset then 3-term track (COEF,HIT) = (2,3),(-4,5),(7,1), MODECP on 1st, MODE0 on 3rd, SHIFT=0 -> RESULT=-7, RES_VALID one cycle, 3 edges after last term, NTERMS=3, ERR=0.
- Single term with MODECP=MODE0=1, COEF=-131072, HIT=131071 -> RESULT = -17179738112 truncated to OUT_W (or saturated to -2147483648 with GF_ACC_SAT_EN, ERR=1).
- DV_IN without MODECP in IDLE -> ERR pulse, no RES_VALID, BUSY stays 0.
- Track of 2 terms, then MODECP before MODE0, then a full 2-term track (1,1),(1,1) -> ERR with NTERMS=2, then RESULT=2 with NTERMS=2.
- Back-to-back tracks with bubbles (DV_IN low 2 cycles mid-track) -> correct sums, one RES_VALID per track, no extra latency beyond the bubbles.
- RESET_N pulsed low mid-track (asynchronous, between edges) -> outputs zero immediately; subsequent track correct.
